deserializer: RTL

//  Receive-side counterpart of the serializer. Consumes the Aurora AXI-Stream RX frame train
//  (one header frame, then NUMBER_PACKET payload frames) and rebuilds the SEND_DATA_WIDTH word.

---
 rtl/deserializer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/deserializer.sv
// Aurora RX frame deserializer: header + NUMBER_PACKET payload frames
// are reassembled into one SEND_DATA_WIDTH word with dst/TTL/source id.
module deserializer #(
  parameter int AURORA_DATA_WIDTH      = 64,
  parameter int SEND_DATA_WIDTH        = 1024,
  parameter int RECOGNIZE_HEADER_WIDTH = 1,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2,
  parameter int HOST_PAYLOAD_WIDTH     = 61,
  parameter int NUMBER_PACKET          = 17,
  parameter int ADDR_WIDTH             = 10,
  parameter int TTL_WIDTH              = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              axis_rx_tvalid,
  input  logic                              axis_rx_tlast,
  input  logic [AURORA_DATA_WIDTH-1:0]      axis_rx_tdata,
  output logic                              recv_data_valid,
  output logic [SEND_DATA_WIDTH-1:0]        v_data_write,
  output logic [ADDR_WIDTH-1:0]             dst_addr_recv,
  output logic [TTL_WIDTH-1:0]              TTL_recv,
  output logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id_recv,
  output logic                              frame_error
);

  localparam int HB = RECOGNIZE_HEADER_WIDTH + RECOGNIZE_ROUTER_WIDTH;
  localparam int CW = $clog2(NUMBER_PACKET);
  localparam int SW = $clog2(SEND_DATA_WIDTH) + 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PAY  = 1'b1;

  logic [0:0]                        r_state;
  logic [CW-1:0]                     r_cnt;
  logic [SEND_DATA_WIDTH-1:0]        r_buf;
  logic [ADDR_WIDTH-1:0]             r_dst;
  logic [TTL_WIDTH-1:0]              r_ttl;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0] r_id;
  logic                              r_valid;
  logic                              r_err;
  logic [SEND_DATA_WIDTH-1:0]        r_data_o;
  logic [ADDR_WIDTH-1:0]             r_dst_o;
  logic [TTL_WIDTH-1:0]              r_ttl_o;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0] r_id_o;

  logic                              w_hdr;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0] w_id;
  logic [ADDR_WIDTH-1:0]             w_dst;
  logic [TTL_WIDTH-1:0]              w_ttl;
  logic                              w_last_cnt;
  logic                              w_bad;
  logic                              w_done;
  logic                              w_step;
  logic [SW-1:0]                     w_shamt;
  logic [SEND_DATA_WIDTH-1:0]        w_slice;
  logic [SEND_DATA_WIDTH-1:0]        w_mask;
  logic [SEND_DATA_WIDTH-1:0]        w_buf_next;

  assign w_hdr = axis_rx_tdata[0];
  assign w_id  = axis_rx_tdata[RECOGNIZE_HEADER_WIDTH +: RECOGNIZE_ROUTER_WIDTH];
  assign w_dst = axis_rx_tdata[HB +: ADDR_WIDTH];
  assign w_ttl = axis_rx_tdata[HB+ADDR_WIDTH +: TTL_WIDTH];

  assign w_last_cnt = (r_cnt == CW'(NUMBER_PACKET-1));
  assign w_bad  = !w_hdr &&
                  ((w_id != r_id) || (axis_rx_tlast != w_last_cnt));
  assign w_done = !w_hdr && !w_bad && w_last_cnt;
  assign w_step = !w_hdr && !w_bad && !w_last_cnt;

  // Bits of the final slice beyond the word width fall off the shift.
  assign w_shamt    = SW'(r_cnt) * SW'(HOST_PAYLOAD_WIDTH);
  assign w_slice    = SEND_DATA_WIDTH'(axis_rx_tdata[HB +: HOST_PAYLOAD_WIDTH])
                      << w_shamt;
  assign w_mask     = SEND_DATA_WIDTH'({HOST_PAYLOAD_WIDTH{1'b1}})
                      << w_shamt;
  assign w_buf_next = (r_buf & ~w_mask) | w_slice;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_dst    <= '0;
      r_ttl    <= '0;
      r_id     <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_data_o <= '0;
      r_dst_o  <= '0;
      r_ttl_o  <= '0;
      r_id_o   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (axis_rx_tvalid) begin
        if (r_state == S_IDLE) begin
          if (w_hdr && !axis_rx_tlast) begin
            r_dst   <= w_dst;
            r_ttl   <= w_ttl;
            r_id    <= w_id;
            r_cnt   <= '0;
            r_state <= S_PAY;
          end else begin
            r_err <= 1'b1;
          end
        end else begin
          unique case (1'b1)
            w_hdr: begin
              // Aborts the current packet; the header itself may restart.
              r_err <= 1'b1;
              if (!axis_rx_tlast) begin
                r_dst <= w_dst;
                r_ttl <= w_ttl;
                r_id  <= w_id;
                r_cnt <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end
            w_bad: begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
            w_done: begin
              r_buf    <= w_buf_next;
              r_data_o <= w_buf_next;
              r_dst_o  <= r_dst;
              r_ttl_o  <= r_ttl;
              r_id_o   <= r_id;
              r_valid  <= 1'b1;
              r_state  <= S_IDLE;
            end
            w_step: begin
              r_buf <= w_buf_next;
              r_cnt <= r_cnt + 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign recv_data_valid = r_valid;
  assign frame_error     = r_err;
  assign v_data_write    = r_data_o;
  assign dst_addr_recv   = r_dst_o;
  assign TTL_recv        = r_ttl_o;
  assign router_id_recv  = r_id_o;

endmodule
